mem_port_arbiter: RTL and testbench

//  Shares the single unified instruction/data memory port of the multicycle core between two requesters:
//   - port 0: core fetch/load/store
//   - port 1: loader/debug DMA

---
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between the core (port 0)
// and the loader/debug DMA (port 1); one access in flight at a time.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ready0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ready1,
  output logic [DATA_W-1:0] rdata1,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic             owner, owner_nxt;
  logic             rr_pri, rr_pri_nxt;
  logic             is_wr, is_wr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= 1'b0;
      rr_pri <= 1'b0;
      is_wr  <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_pri <= rr_pri_nxt;
      is_wr  <= is_wr_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // Outputs decode from state so an async reset clears them in the same cycle.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_pri_nxt = rr_pri;
    is_wr_nxt  = is_wr;
    cnt_nxt    = cnt;
    busy       = 1'b0;
    gnt        = 2'b00;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    ready0     = 1'b0;
    ready1     = 1'b0;
    rdata0     = '0;
    rdata1     = '0;

    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          owner_nxt = (req0 && req1) ? rr_pri : req1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        busy      = 1'b1;
        gnt       = owner ? 2'b10 : 2'b01;
        mem_en    = 1'b1;
        mem_we    = owner ? we1 : we0;
        mem_addr  = owner ? addr1 : addr0;
        mem_wdata = owner ? wdata1 : wdata0;
        is_wr_nxt = mem_we;
        cnt_nxt   = CNT_W'(MEM_LAT - 1);
        state_nxt = (MEM_LAT == 1) ? DONE : WAIT;
      end
      WAIT: begin
        busy    = 1'b1;
        gnt     = owner ? 2'b10 : 2'b01;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        busy = 1'b1;
        gnt  = owner ? 2'b10 : 2'b01;
        if (owner) begin
          ready1 = 1'b1;
          rdata1 = is_wr ? '0 : mem_rdata;
        end else begin
          ready0 = 1'b1;
          rdata0 = is_wr ? '0 : mem_rdata;
        end
        rr_pri_nxt = ~owner;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance a (MEM_LAT=1) and instance b (MEM_LAT=3), each with its own memory model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_req0, a_we0, a_ready0, a_req1, a_we1, a_ready1, a_busy, a_mem_en, a_mem_we;
  logic [31:0] a_addr0, a_wdata0, a_rdata0, a_addr1, a_wdata1, a_rdata1;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [1:0]  a_gnt;

  logic        b_req0, b_we0, b_ready0, b_req1, b_we1, b_ready1, b_busy, b_mem_en, b_mem_we;
  logic [31:0] b_addr0, b_wdata0, b_rdata0, b_addr1, b_wdata1, b_rdata1;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [1:0]  b_gnt;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .req0(a_req0), .we0(a_we0), .addr0(a_addr0), .wdata0(a_wdata0), .ready0(a_ready0), .rdata0(a_rdata0),
    .req1(a_req1), .we1(a_we1), .addr1(a_addr1), .wdata1(a_wdata1), .ready1(a_ready1), .rdata1(a_rdata1),
    .gnt(a_gnt), .busy(a_busy), .mem_en(a_mem_en), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0), .ready0(b_ready0), .rdata0(b_rdata0),
    .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1), .ready1(b_ready1), .rdata1(b_rdata1),
    .gnt(b_gnt), .busy(b_busy), .mem_en(b_mem_en), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Memory model a: one-cycle read latency; preloaded while rst is high.
  logic [31:0] mem_a [0:255];
  logic [31:0] rd_a;
  always @(posedge clk) begin
    if (rst) begin
      mem_a[8'h40] <= 32'hDEADBEEF;
    end else if (a_mem_en) begin
      if (a_mem_we) mem_a[a_mem_addr[9:2]] <= a_mem_wdata;
      else          rd_a <= mem_a[a_mem_addr[9:2]];
    end
  end
  assign a_mem_rdata = rd_a;

  // Memory model b: three-cycle read latency.
  logic [31:0] mem_b [0:255];
  logic [31:0] rd_b1, rd_b2, rd_b3;
  always @(posedge clk) begin
    if (rst) begin
      mem_b[8'h10] <= 32'hCAFEF00D;
      mem_b[8'h11] <= 32'h0BADF00D;
    end else if (b_mem_en) begin
      if (b_mem_we) mem_b[b_mem_addr[9:2]] <= b_mem_wdata;
      else          rd_b1 <= mem_b[b_mem_addr[9:2]];
    end
    rd_b2 <= rd_b1;
    rd_b3 <= rd_b2;
  end
  assign b_mem_rdata = rd_b3;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  initial begin
    rst = 1'b1;
    {a_req0, a_we0, a_req1, a_we1, b_req0, b_we0, b_req1, b_we1} = '0;
    {a_addr0, a_wdata0, a_addr1, a_wdata1} = '0;
    {b_addr0, b_wdata0, b_addr1, b_wdata1} = '0;
    step();
    step();
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_gnt", 64'(a_gnt), 64'd0);
    chk("rst_mem_en", 64'(a_mem_en), 64'd0);
    chk("rst_ready", 64'({a_ready0, a_ready1, b_ready0, b_ready1}), 64'd0);
    rst = 1'b0;
    step();

    // 1: port 0 read, MEM_LAT=1
    a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 32'h100;
    step();
    chk("t1_mem_en", 64'(a_mem_en), 64'd1);
    chk("t1_mem_addr", 64'(a_mem_addr), 64'h100);
    chk("t1_mem_we", 64'(a_mem_we), 64'd0);
    chk("t1_gnt", 64'(a_gnt), 64'd1);
    step();
    chk("t1_ready0", 64'(a_ready0), 64'd1);
    chk("t1_rdata0", 64'(a_rdata0), 64'hDEADBEEF);
    chk("t1_ready1", 64'(a_ready1), 64'd0);
    chk("t1_done_mem_en", 64'(a_mem_en), 64'd0);
    a_req0 = 1'b0;
    step();
    chk("t1_idle_busy", 64'(a_busy), 64'd0);
    chk("t1_idle_rdata0", 64'(a_rdata0), 64'd0);

    // 2: port 1 write, then port 0 reads it back
    a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 32'h20; a_wdata1 = 32'h12345678;
    step();
    chk("t2_mem_en", 64'(a_mem_en), 64'd1);
    chk("t2_mem_we", 64'(a_mem_we), 64'd1);
    chk("t2_mem_addr", 64'(a_mem_addr), 64'h20);
    chk("t2_mem_wdata", 64'(a_mem_wdata), 64'h12345678);
    chk("t2_gnt", 64'(a_gnt), 64'd2);
    step();
    chk("t2_ready1", 64'(a_ready1), 64'd1);
    chk("t2_rdata1_wr", 64'(a_rdata1), 64'd0);
    chk("t2_ready0", 64'(a_ready0), 64'd0);
    chk("t2_done_mem_we", 64'(a_mem_we), 64'd0);
    a_req1 = 1'b0; a_we1 = 1'b0;
    step();
    a_req0 = 1'b1; a_addr0 = 32'h20;
    step();
    step();
    chk("t2_rb_ready0", 64'(a_ready0), 64'd1);
    chk("t2_rb_rdata0", 64'(a_rdata0), 64'h12345678);
    a_req0 = 1'b0;
    step();

    // 3: both ports held; fresh reset puts port 0 first
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_req0 = 1'b1; a_addr0 = 32'h100;
    a_req1 = 1'b1; a_addr1 = 32'h20;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t3_acc_gnt", 64'(a_gnt), (i % 2 == 0) ? 64'd1 : 64'd2);
      step();
      chk("t3_done_gnt", 64'(a_gnt), (i % 2 == 0) ? 64'd1 : 64'd2);
      chk("t3_ready0", 64'(a_ready0), (i % 2 == 0) ? 64'd1 : 64'd0);
      chk("t3_ready1", 64'(a_ready1), (i % 2 == 0) ? 64'd0 : 64'd1);
      if (i % 2 == 0) chk("t3_rdata0", 64'(a_rdata0), 64'hDEADBEEF);
      else            chk("t3_rdata1", 64'(a_rdata1), 64'h12345678);
      if (i == 5) begin
        a_req0 = 1'b0;
        a_req1 = 1'b0;
      end
      step();
      chk("t3_idle_busy", 64'(a_busy), 64'd0);
    end

    // 4: MEM_LAT=3 read
    b_req0 = 1'b1; b_addr0 = 32'h40;
    step();
    chk("t4_mem_en", 64'(b_mem_en), 64'd1);
    chk("t4_mem_addr", 64'(b_mem_addr), 64'h40);
    step();
    chk("t4_w1_mem_en", 64'(b_mem_en), 64'd0);
    chk("t4_w1_busy", 64'(b_busy), 64'd1);
    chk("t4_w1_ready0", 64'(b_ready0), 64'd0);
    step();
    chk("t4_w2_mem_en", 64'(b_mem_en), 64'd0);
    chk("t4_w2_ready0", 64'(b_ready0), 64'd0);
    step();
    chk("t4_ready0", 64'(b_ready0), 64'd1);
    chk("t4_rdata0", 64'(b_rdata0), 64'hCAFEF00D);
    chk("t4_done_mem_en", 64'(b_mem_en), 64'd0);
    b_req0 = 1'b0;
    step();
    chk("t4_idle_busy", 64'(b_busy), 64'd0);

    // 5: reset asserted while in WAIT
    b_req0 = 1'b1; b_addr0 = 32'h40;
    step();
    step();
    chk("t5_in_wait", 64'(b_busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_mem_en", 64'(b_mem_en), 64'd0);
    chk("t5_busy", 64'(b_busy), 64'd0);
    chk("t5_gnt", 64'(b_gnt), 64'd0);
    chk("t5_ready", 64'({b_ready0, b_ready1}), 64'd0);
    b_req0 = 1'b0;
    step();
    chk("t5_rst_ready", 64'({b_ready0, b_ready1}), 64'd0);
    rst = 1'b0;
    step();
    b_req0 = 1'b1; b_addr0 = 32'h44;
    step();
    chk("t5_fresh_mem_en", 64'(b_mem_en), 64'd1);
    step();
    step();
    step();
    chk("t5_fresh_ready0", 64'(b_ready0), 64'd1);
    chk("t5_fresh_rdata0", 64'(b_rdata0), 64'h0BADF00D);
    b_req0 = 1'b0;
    step();

    // 6: req0 dropped during WAIT with req1 pending
    b_req0 = 1'b1; b_addr0 = 32'h40;
    step();
    chk("t6_gnt0", 64'(b_gnt), 64'd1);
    b_req1 = 1'b1; b_addr1 = 32'h44;
    step();
    b_req0 = 1'b0;
    step();
    step();
    chk("t6_ready0", 64'(b_ready0), 64'd1);
    chk("t6_rdata0", 64'(b_rdata0), 64'hCAFEF00D);
    chk("t6_ready1", 64'(b_ready1), 64'd0);
    step();
    chk("t6_idle_gnt", 64'(b_gnt), 64'd0);
    chk("t6_idle_busy", 64'(b_busy), 64'd0);
    step();
    chk("t6_acc_gnt", 64'(b_gnt), 64'd2);
    chk("t6_acc_addr", 64'(b_mem_addr), 64'h44);
    step();
    step();
    step();
    chk("t6_ready1_done", 64'(b_ready1), 64'd1);
    chk("t6_rdata1", 64'(b_rdata1), 64'h0BADF00D);
    chk("t6_ready0_done", 64'(b_ready0), 64'd0);
    b_req1 = 1'b0;
    step();
    chk("t6_end_busy", 64'(b_busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
